sbg_xy_encoder: RTL and testbench
=================================

// Module: sbg_xy_encoder
// PURPOSE
//   Producer side of the 2-bit XY pitch-event interface consumed by the baseball game FSM.
//   - Takes single-cycle event pulses from the debounced umpire buttons.
//   - Encodes each pulse to XY: 00 hit, 01 out, 10 ball, 11 strike.
//   - Buffers codes in a small FIFO and presents them with a valid/ready handshake, so no event is lost while the FSM is stalled.
// PARAMETERS
//   DEPTH  4  FIFO entries; power of two, >= 2
//   AW     2  pointer width = log2(DEPTH)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   reset, synchronous, active-high
//   btn_hit    in   1   hit event pulse (one cycle per event)
//   btn_out    in   1   out event pulse
//   btn_ball   in   1   ball event pulse
//   btn_strike in   1   strike event pulse
//   XY         out  2   head-of-FIFO event code; 2'b00 when XY_valid=0
//   XY_valid   out  1   XY holds a buffered event
//   XY_ready   in   1   consumer accepts XY this cycle
//   count      out  AW+1  entries currently buffered, 0..DEPTH
//   overflow   out  1   sticky: event dropped because FIFO full
//   multi_err  out  1   sticky: more than one button high in the same cycle
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all outputs 0, pointers 0, FIFO empty. Reset beats every other input in that cycle.
//   - Encode: push = OR of the buttons. When more than one button is high, exactly one code is pushed.
//     Priority: out > strike > ball > hit. multi_err is set on the next edge.
//   - Push: accepted at posedge when count<DEPTH, or when count==DEPTH and a pop happens the same edge.
//     Full with no pop: the event is dropped and overflow is set. FIFO contents are unchanged.
//   - Pop: happens at posedge when XY_valid && XY_ready. XY_ready while XY_valid=0 is ignored.
//   - Latency: a button at edge n gives XY_valid=1 with the code after edge n. There is no same-cycle bypass.
//   - XY and XY_valid are stable while XY_valid=1 and XY_ready=0.
//   - Simultaneous push and pop:
//     - count==0: push only. Nothing is valid yet, so no pop.
//     - 0<count<DEPTH: count unchanged; head advances; new code goes to the tail.
//     - count==DEPTH: accepted; count stays DEPTH; overflow is not set.
//   - Pointers wrap modulo DEPTH. Full/empty come from count, not from pointer equality.
//   - overflow and multi_err clear only on rst.
//   - A reset in the middle of a stream discards every buffered event. No partial code is presented afterwards.
// CONFIGURATION
//   SBG_ENC_STATS_EN
//     - Defined: adds outputs n_hit, n_out, n_ball, n_strike (8 bits each).
//       Each counts codes accepted into the FIFO; dropped events are not counted.
//       Counters saturate at 255 and reset to 0.
//     - Undefined: those ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//   - Shared package sbg_pkg holds:
//     - localparams XY_HIT=2'b00, XY_OUT=2'b01, XY_BALL=2'b10, XY_STRIKE=2'b11.
//     - a function encoding the priority from the four button bits.
//     - the game FSM imports the same constants.
//   - Sub-module sbg_fifo (DEPTH, WIDTH=2): storage, pointers, count.
//     The top level keeps the encoder, the sticky flags and the optional stats.
// TESTING
//   1. Reset then idle: rst=1 for 2 cycles -> XY=00, XY_valid=0, count=0, overflow=0, multi_err=0.
//   2. Ordered stream, XY_ready=1:
//      - stimulus: pulses ball, strike, ball, hit on consecutive cycles.
//      - response: XY = 10, 11, 10, 00 on consecutive cycles, each one cycle after its button; count never exceeds 1.
//   3. Stall and full:
//      - stimulus: XY_ready=0; 5 strike pulses with DEPTH=4.
//      - response: count=4, overflow=1.
//      - then XY_ready=1: exactly four 11 codes, then XY_valid=0.
//   4. Simultaneous buttons: btn_ball=btn_out=1 in one cycle -> single code 01 queued, multi_err=1, count=1.
//   5. Full with push and pop: count=4, XY_ready=1 and btn_hit in the same cycle -> count stays 4, overflow stays 0, hit code reaches the head 4 pops later.
//   6. Mid-stream reset: 3 events queued, rst=1 for one cycle -> XY_valid=0 and count=0 the next cycle.
//      With SBG_ENC_STATS_EN defined, all n_* read 0.

Source files
------------

// File: rtl/sbg_pkg.sv
// Shared XY event codes and the button-priority encoder.
// These definitions are shared by the encoder and the game FSM.
package sbg_pkg;

    localparam logic [1:0] XY_HIT    = 2'b00;
    localparam logic [1:0] XY_OUT    = 2'b01;
    localparam logic [1:0] XY_BALL   = 2'b10;
    localparam logic [1:0] XY_STRIKE = 2'b11;

    typedef struct packed {
        logic hit;
        logic out;
        logic ball;
        logic strike;
    } btn_t;

    // Priority: out > strike > ball > hit.
    function automatic logic [1:0] sbg_encode(input btn_t b);
        logic [1:0] code;
        code = XY_HIT;
        if (b.out)         code = XY_OUT;
        else if (b.strike) code = XY_STRIKE;
        else if (b.ball)   code = XY_BALL;
        return code;
    endfunction

    function automatic logic sbg_multi(input btn_t b);
        logic [2:0] n;
        n = {2'b00, b.hit} + {2'b00, b.out} + {2'b00, b.ball} + {2'b00, b.strike};
        return (n > 3'd1);
    endfunction

endpackage

// File: rtl/sbg_fifo.sv
// Purpose: count-tracked circular FIFO for XY event codes.
// Latency: a write at edge n is readable after edge n; no write-to-read bypass.
// Backpressure: writes are refused when full unless a read happens on the same edge.
module sbg_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_acc,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_fire;

    // Full and empty are derived from count; pointers may be equal in both cases.
    assign rd_vld  = (count != '0);
    assign rd_fire = rd_vld && rd_rdy;
    assign wr_acc  = wr_vld && ((count != FULL_CNT) || rd_fire);
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sbg_xy_encoder.sv
// Purpose: encode umpire button pulses to XY codes, buffer them, present via valid/ready.
// Latency: button at edge n -> XY_valid with its code after edge n.
// Backpressure: up to DEPTH events held while XY_ready=0; further events dropped and flagged.
// Optional SBG_ENC_STATS_EN adds saturating per-code accepted-event counters.
module sbg_xy_encoder
    import sbg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_hit,
    input  logic          btn_out,
    input  logic          btn_ball,
    input  logic          btn_strike,
    output logic [1:0]    XY,
    output logic          XY_valid,
    input  logic          XY_ready,
    output logic [AW:0]   count,
    output logic          overflow,
`ifdef SBG_ENC_STATS_EN
    output logic [7:0]    n_hit,
    output logic [7:0]    n_out,
    output logic [7:0]    n_ball,
    output logic [7:0]    n_strike,
`endif
    output logic          multi_err
);

    btn_t       btn;
    logic       push_vld;
    logic [1:0] push_dat;
    logic       push_acc;

    assign btn      = '{hit: btn_hit, out: btn_out, ball: btn_ball, strike: btn_strike};
    assign push_vld = btn_hit | btn_out | btn_ball | btn_strike;
    assign push_dat = sbg_encode(btn);

    sbg_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (2)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .wr_acc (push_acc),
        .rd_vld (XY_valid),
        .rd_dat (XY),
        .rd_rdy (XY_ready),
        .count  (count)
    );

    // A push refused by the FIFO can only mean full without a same-edge pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            if (push_vld && !push_acc) overflow  <= 1'b1;
            if (sbg_multi(btn))        multi_err <= 1'b1;
        end
    end

`ifdef SBG_ENC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            n_hit    <= 8'd0;
            n_out    <= 8'd0;
            n_ball   <= 8'd0;
            n_strike <= 8'd0;
        end else if (push_acc) begin
            case (push_dat)
                XY_HIT:    if (n_hit    != 8'hFF) n_hit    <= n_hit    + 8'd1;
                XY_OUT:    if (n_out    != 8'hFF) n_out    <= n_out    + 8'd1;
                XY_BALL:   if (n_ball   != 8'hFF) n_ball   <= n_ball   + 8'd1;
                default:   if (n_strike != 8'hFF) n_strike <= n_strike + 8'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sbg_xy_encoder.sv
// Directed bench for sbg_xy_encoder: reset, stream, stall/full, multi-button, full push+pop, mid-stream reset.
module tb_sbg_xy_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_hit, btn_out, btn_ball, btn_strike;
    logic [1:0] XY;
    logic       XY_valid;
    logic       XY_ready;
    logic [2:0] count;
    logic       overflow;
    logic       multi_err;
`ifdef SBG_ENC_STATS_EN
    logic [7:0] n_hit, n_out, n_ball, n_strike;
`endif

    int vectors = 0;
    int miscompares = 0;

    sbg_xy_encoder #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_hit    (btn_hit),
        .btn_out    (btn_out),
        .btn_ball   (btn_ball),
        .btn_strike (btn_strike),
        .XY         (XY),
        .XY_valid   (XY_valid),
        .XY_ready   (XY_ready),
        .count      (count),
        .overflow   (overflow),
`ifdef SBG_ENC_STATS_EN
        .n_hit      (n_hit),
        .n_out      (n_out),
        .n_ball     (n_ball),
        .n_strike   (n_strike),
`endif
        .multi_err  (multi_err)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic h, input logic o, input logic b, input logic s);
        btn_hit = h; btn_out = o; btn_ball = b; btn_strike = s;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_btn(0, 0, 0, 0);
        XY_ready = 1'b0;
        do_reset(2);
        vectors++; if (XY !== 2'b00) begin miscompares++; $display("FAIL reset_xy got %b exp 00", XY); end
        vectors++; if (XY_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", XY_valid); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        vectors++; if (multi_err !== 1'b0) begin miscompares++; $display("FAIL reset_multi got %b exp 0", multi_err); end
`ifdef SBG_ENC_STATS_EN
        vectors++; if ({n_hit, n_out, n_ball, n_strike} !== 32'd0) begin miscompares++; $display("FAIL reset_stats got %h exp 0", {n_hit, n_out, n_ball, n_strike}); end
`endif
        // Ready with nothing buffered must not disturb anything.
        XY_ready = 1'b1;
        step();
        vectors++; if (XY_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL idle_ready got v=%b c=%0d exp v=0 c=0", XY_valid, count); end
    endtask

    task automatic test_stream();
        logic [1:0] exp_code [4];
        logic [3:0] btn_vec  [4];
        exp_code = '{2'b10, 2'b11, 2'b10, 2'b00};
        btn_vec  = '{4'b0010, 4'b0001, 4'b0010, 4'b1000};
        XY_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_btn(btn_vec[i][3], btn_vec[i][2], btn_vec[i][1], btn_vec[i][0]);
            step();
            vectors++; if (XY_valid !== 1'b1 || XY !== exp_code[i]) begin miscompares++; $display("FAIL stream_%0d got v=%b xy=%b exp v=1 xy=%b", i, XY_valid, XY, exp_code[i]); end
            vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL stream_count_%0d got %0d exp 1", i, count); end
        end
        set_btn(0, 0, 0, 0);
        step();
        vectors++; if (XY_valid !== 1'b0 || XY !== 2'b00 || count !== 3'd0) begin miscompares++; $display("FAIL stream_drain got v=%b xy=%b c=%0d exp v=0 xy=00 c=0", XY_valid, XY, count); end
    endtask

    task automatic test_stall_full();
        do_reset(1);
        XY_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_btn(0, 0, 0, 1);
            step();
            set_btn(0, 0, 0, 0);
            if (i == 3) begin
                vectors++; if (count !== 3'd4 || overflow !== 1'b0) begin miscompares++; $display("FAIL fill_4 got c=%0d ovf=%b exp c=4 ovf=0", count, overflow); end
            end
        end
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d exp 4", count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL full_overflow got %b exp 1", overflow); end
        step();
        vectors++; if (XY_valid !== 1'b1 || XY !== 2'b11 || count !== 3'd4) begin miscompares++; $display("FAIL stall_hold got v=%b xy=%b c=%0d exp v=1 xy=11 c=4", XY_valid, XY, count); end
        XY_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (XY_valid !== 1'b1 || XY !== 2'b11) begin miscompares++; $display("FAIL drain_%0d got v=%b xy=%b exp v=1 xy=11", i, XY_valid, XY); end
            step();
        end
        vectors++; if (XY_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL drain_empty got v=%b c=%0d exp v=0 c=0", XY_valid, count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_multi();
        do_reset(1);
        XY_ready = 1'b0;
        set_btn(0, 1, 1, 0);
        step();
        set_btn(0, 0, 0, 0);
        vectors++; if (XY !== 2'b01 || XY_valid !== 1'b1) begin miscompares++; $display("FAIL multi_code got v=%b xy=%b exp v=1 xy=01", XY_valid, XY); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL multi_count got %0d exp 1", count); end
        vectors++; if (multi_err !== 1'b1) begin miscompares++; $display("FAIL multi_err got %b exp 1", multi_err); end
        // Strike beats ball and hit when out is absent.
        set_btn(1, 0, 1, 1);
        step();
        set_btn(0, 0, 0, 0);
        XY_ready = 1'b1;
        step();
        vectors++; if (XY !== 2'b11 || count !== 3'd1) begin miscompares++; $display("FAIL prio_strike got xy=%b c=%0d exp xy=11 c=1", XY, count); end
        step();
    endtask

    task automatic test_full_push_pop();
        logic [3:0] fill [4];
        logic [1:0] exp_head [4];
        fill     = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
        exp_head = '{2'b10, 2'b01, 2'b11, 2'b00};
        do_reset(1);
        XY_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_btn(fill[i][3], fill[i][2], fill[i][1], fill[i][0]);
            step();
        end
        vectors++; if (count !== 3'd4 || XY !== 2'b11) begin miscompares++; $display("FAIL pp_fill got c=%0d xy=%b exp c=4 xy=11", count, XY); end
        set_btn(1, 0, 0, 0);
        XY_ready = 1'b1;
        step();
        set_btn(0, 0, 0, 0);
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL pp_count got %0d exp 4", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL pp_overflow got %b exp 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (XY_valid !== 1'b1 || XY !== exp_head[i]) begin miscompares++; $display("FAIL pp_head_%0d got v=%b xy=%b exp v=1 xy=%b", i, XY_valid, XY, exp_head[i]); end
            step();
        end
        vectors++; if (XY_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL pp_empty got v=%b c=%0d exp v=0 c=0", XY_valid, count); end
    endtask

    task automatic test_midstream_reset();
        do_reset(1);
        XY_ready = 1'b0;
        set_btn(1, 0, 0, 0); step();
        set_btn(0, 1, 0, 0); step();
        set_btn(0, 0, 1, 0); step();
        set_btn(0, 0, 0, 0);
        vectors++; if (count !== 3'd3 || XY !== 2'b00 || XY_valid !== 1'b1) begin miscompares++; $display("FAIL mid_queued got c=%0d v=%b xy=%b exp c=3 v=1 xy=00", count, XY_valid, XY); end
`ifdef SBG_ENC_STATS_EN
        vectors++; if ({n_hit, n_out, n_ball, n_strike} !== {8'd1, 8'd1, 8'd1, 8'd0}) begin miscompares++; $display("FAIL mid_stats got %h exp 01010100", {n_hit, n_out, n_ball, n_strike}); end
`endif
        // Reset wins over a same-cycle button and ready.
        set_btn(0, 0, 0, 1);
        XY_ready = 1'b1;
        do_reset(1);
        set_btn(0, 0, 0, 0);
        vectors++; if (XY_valid !== 1'b0 || count !== 3'd0 || XY !== 2'b00) begin miscompares++; $display("FAIL mid_reset got v=%b c=%0d xy=%b exp v=0 c=0 xy=00", XY_valid, count, XY); end
`ifdef SBG_ENC_STATS_EN
        vectors++; if ({n_hit, n_out, n_ball, n_strike} !== 32'd0) begin miscompares++; $display("FAIL mid_stats_clr got %h exp 0", {n_hit, n_out, n_ball, n_strike}); end
`endif
        step();
        vectors++; if (XY_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL mid_after got v=%b c=%0d exp v=0 c=0", XY_valid, count); end
    endtask

    initial begin
        rst = 1'b1;
        XY_ready = 1'b0;
        set_btn(0, 0, 0, 0);
        #2;
        test_reset();
        test_stream();
        test_stall_full();
        test_multi();
        test_full_push_pop();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
